// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding and default parameters for the hazard control unit.
package hazard_pkg;
   localparam int DEF_REG_W      = 5;
   localparam int DEF_LOAD_LAT   = 1;
   localparam int DEF_MULDIV_LAT = 4;
   localparam int DEF_CNT_W      = 16;
   typedef logic [1:0] state_t;
   localparam state_t IDLE     = 2'd0;
   localparam state_t LD_STALL = 2'd1;
   localparam state_t MD_BUSY  = 2'd2;
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side hazard inputs and pipeline-control outputs.
interface hazard_ctrl_if import hazard_pkg::*; #(
   parameter int REG_W = DEF_REG_W,
   parameter int CNT_W = DEF_CNT_W
);
   logic [REG_W-1:0] id_rs, id_rt, ex_rt;
   logic             id_uses_rs, id_uses_rt, ex_mem_read, ex_muldiv_start, branch_taken;
   logic             pc_write, ifid_write, idex_bubble, ifid_flush, busy;
   logic [CNT_W-1:0] stall_cnt;
   modport master (
      output id_rs, id_rt, ex_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_muldiv_start, branch_taken,
      input  pc_write, ifid_write, idex_bubble, ifid_flush, busy, stall_cnt
   );
   modport slave (
      input  id_rs, id_rt, ex_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_muldiv_start, branch_taken,
      output pc_write, ifid_write, idex_bubble, ifid_flush, busy, stall_cnt
   );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: increment-enabled counter that holds at all-ones.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);
   logic [CNT_W-1:0] r_cnt;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) r_cnt <= '0;
      else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
   assign o_cnt = r_cnt;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use and multi-cycle-op stall control with taken-branch flush.
// Stalls assert combinationally in the detection cycle; the FSM covers any further cycles.
module hazard_ctrl import hazard_pkg::*; #(
   parameter int REG_W      = DEF_REG_W,
   parameter int LOAD_LAT   = DEF_LOAD_LAT,
   parameter int MULDIV_LAT = DEF_MULDIV_LAT,
   parameter int CNT_W      = DEF_CNT_W
) (
   input logic          clk,
   input logic          reset_n,
   hazard_ctrl_if.slave bus
);
   localparam bit MD_STALL = MULDIV_LAT > 1;
   localparam bit MD_MULTI = MULDIV_LAT > 2;
   localparam bit LD_MULTI = LOAD_LAT > 1;
   // rem = busy cycles still to come after the current one; a multi-cycle op
   // stalls its follower MULDIV_LAT-1 cycles, a load-use LOAD_LAT cycles
   localparam logic [3:0] MD_REM = 4'(MD_MULTI ? MULDIV_LAT - 3 : 0);
   localparam logic [3:0] LD_REM = 4'(LD_MULTI ? LOAD_LAT - 2 : 0);
   logic [REG_W-1:0] w_rs, w_rt, w_ex_rt;
   logic [CNT_W-1:0] w_cnt;
   logic             w_idle, w_load_hit, w_md_go, w_ld_go, w_stall;
   state_t           r_state, w_nstate;
   logic [3:0]       r_rem, w_nrem;
   assign w_rs       = bus.id_rs;
   assign w_rt       = bus.id_rt;
   assign w_ex_rt    = bus.ex_rt;
   assign w_load_hit = bus.ex_mem_read && w_ex_rt != '0 &&
                       ((bus.id_uses_rs && w_rs == w_ex_rt) || (bus.id_uses_rt && w_rt == w_ex_rt));
   assign w_idle     = r_state == IDLE;
   // a taken branch squashes the ID instruction, so neither hazard applies
   assign w_md_go    = w_idle && !bus.branch_taken && bus.ex_muldiv_start && MD_STALL;
   assign w_ld_go    = w_idle && !bus.branch_taken && w_load_hit && !w_md_go;
   assign w_stall    = !w_idle || w_md_go || w_ld_go;
   always_comb begin
      w_nstate = r_state;
      w_nrem   = r_rem;
      if (w_idle) begin
         if (w_md_go && MD_MULTI) begin
            w_nstate = MD_BUSY;
            w_nrem   = MD_REM;
         end else if (w_ld_go && LD_MULTI) begin
            w_nstate = LD_STALL;
            w_nrem   = LD_REM;
         end
      end else if (r_rem == 4'd0) w_nstate = IDLE;
      else w_nrem = r_rem - 4'd1;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_state <= IDLE;
         r_rem   <= 4'd0;
      end else begin
         r_state <= w_nstate;
         r_rem   <= w_nrem;
      end
   sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .i_inc   (w_stall),
      .o_cnt   (w_cnt)
   );
   assign bus.pc_write    = !w_stall;
   assign bus.ifid_write  = !w_stall;
   assign bus.idex_bubble = w_stall;
   assign bus.ifid_flush  = w_idle && bus.branch_taken;
   assign bus.busy        = !w_idle;
   assign bus.stall_cnt   = w_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of two hazard_ctrl configurations
// (A: LOAD_LAT=1 MULDIV_LAT=4 CNT_W=16, B: LOAD_LAT=3 MULDIV_LAT=1 CNT_W=2).
module tb_hazard_ctrl;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   always #5 clk = ~clk;
   hazard_ctrl_if #(.REG_W(5), .CNT_W(16)) ia ();
   hazard_ctrl_if #(.REG_W(5), .CNT_W(2))  ib ();
   hazard_ctrl #(.REG_W(5), .LOAD_LAT(1), .MULDIV_LAT(4), .CNT_W(16)) u_a (
      .clk(clk), .reset_n(reset_n), .bus(ia));
   hazard_ctrl #(.REG_W(5), .LOAD_LAT(3), .MULDIV_LAT(1), .CNT_W(2)) u_b (
      .clk(clk), .reset_n(reset_n), .bus(ib));
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic drive_a(input logic [4:0] rs, rt, input logic urs, urt,
                          input logic [4:0] ert, input logic mr, md, br);
      ia.id_rs = rs; ia.id_rt = rt; ia.id_uses_rs = urs; ia.id_uses_rt = urt;
      ia.ex_rt = ert; ia.ex_mem_read = mr; ia.ex_muldiv_start = md; ia.branch_taken = br;
   endtask
   task automatic drive_b(input logic [4:0] rs, rt, input logic urs, urt,
                          input logic [4:0] ert, input logic mr, md, br);
      ib.id_rs = rs; ib.id_rt = rt; ib.id_uses_rs = urs; ib.id_uses_rt = urt;
      ib.ex_rt = ert; ib.ex_mem_read = mr; ib.ex_muldiv_start = md; ib.branch_taken = br;
   endtask
   task automatic step;
      @(negedge clk);
   endtask
   initial begin
      drive_a(0, 0, 0, 0, 0, 0, 0, 0);
      drive_b(0, 0, 0, 0, 0, 0, 0, 0);
      #3;
      chk("rst_pc_write", ia.pc_write, 1);
      chk("rst_ifid_write", ia.ifid_write, 1);
      chk("rst_bubble", ia.idex_bubble, 0);
      chk("rst_flush", ia.ifid_flush, 0);
      chk("rst_busy", ia.busy, 0);
      chk("rst_cnt", ia.stall_cnt, 0);
      step; step;
      reset_n = 1'b1;
      // load-use on rs, LOAD_LAT=1
      step; drive_a(8, 0, 1, 0, 8, 1, 0, 0); #1;
      chk("ld_pc_write", ia.pc_write, 0);
      chk("ld_ifid_write", ia.ifid_write, 0);
      chk("ld_bubble", ia.idex_bubble, 1);
      chk("ld_busy", ia.busy, 0);
      step; drive_a(0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("ld_after_pc_write", ia.pc_write, 1);
      chk("ld_after_busy", ia.busy, 0);
      chk("ld_cnt1", ia.stall_cnt, 1);
      // no hazard: ex_rt zero, or rs not read
      step; drive_a(0, 0, 1, 0, 0, 1, 0, 0); #1;
      chk("ld_r0_pc_write", ia.pc_write, 1);
      step; drive_a(8, 0, 0, 0, 8, 1, 0, 0); #1;
      chk("ld_nouse_bubble", ia.idex_bubble, 0);
      step; drive_a(3, 8, 1, 0, 8, 1, 0, 0); #1;
      chk("ld_rt_unused_bubble", ia.idex_bubble, 0);
      // load-use via rt
      step; drive_a(3, 8, 1, 1, 8, 1, 0, 0); #1;
      chk("ld_rt_bubble", ia.idex_bubble, 1);
      step; drive_a(0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("ld_rt_cnt2", ia.stall_cnt, 2);
      // taken branch beats a load hit
      step; drive_a(8, 0, 1, 0, 8, 1, 0, 1); #1;
      chk("br_flush", ia.ifid_flush, 1);
      chk("br_pc_write", ia.pc_write, 1);
      chk("br_bubble", ia.idex_bubble, 0);
      step; drive_a(0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("br_cnt", ia.stall_cnt, 2);
      chk("br_busy", ia.busy, 0);
      // multi-cycle op, MULDIV_LAT=4: three stall cycles
      step; drive_a(0, 0, 0, 0, 0, 0, 1, 0); #1;
      chk("md_c1_pc_write", ia.pc_write, 0);
      chk("md_c1_busy", ia.busy, 0);
      step; drive_a(0, 0, 0, 0, 0, 0, 0, 1); #1;
      chk("md_c2_busy", ia.busy, 1);
      chk("md_c2_pc_write", ia.pc_write, 0);
      chk("md_c2_flush_ignored", ia.ifid_flush, 0);
      step; drive_a(0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("md_c3_busy", ia.busy, 1);
      chk("md_c3_bubble", ia.idex_bubble, 1);
      step; #1;
      chk("md_c4_busy", ia.busy, 0);
      chk("md_c4_pc_write", ia.pc_write, 1);
      chk("md_cnt5", ia.stall_cnt, 5);
      // muldiv and load hit together: muldiv path wins
      step; drive_a(8, 0, 1, 0, 8, 1, 1, 0); #1;
      chk("both_c1_bubble", ia.idex_bubble, 1);
      step; drive_a(0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("both_c2_busy", ia.busy, 1);
      step; #1;
      chk("both_c3_busy", ia.busy, 1);
      step; #1;
      chk("both_c4_busy", ia.busy, 0);
      chk("both_cnt8", ia.stall_cnt, 8);
      // reset in MD_BUSY with rem=1
      step; drive_a(0, 0, 0, 0, 0, 0, 1, 0);
      step; drive_a(0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("mdrst_pre_busy", ia.busy, 1);
      #1 reset_n = 1'b0; #1;
      chk("mdrst_pc_write", ia.pc_write, 1);
      chk("mdrst_bubble", ia.idex_bubble, 0);
      chk("mdrst_busy", ia.busy, 0);
      chk("mdrst_cnt", ia.stall_cnt, 0);
      step; reset_n = 1'b1;
      step; #1;
      chk("mdrst_after_pc_write", ia.pc_write, 1);
      chk("mdrst_after_busy", ia.busy, 0);
      chk("mdrst_after_cnt", ia.stall_cnt, 0);
      // config B: MULDIV_LAT=1 never stalls
      step; drive_b(0, 0, 0, 0, 0, 0, 1, 0); #1;
      chk("b_md1_pc_write", ib.pc_write, 1);
      step; drive_b(0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("b_md1_busy", ib.busy, 0);
      chk("b_md1_cnt", ib.stall_cnt, 0);
      // config B: LOAD_LAT=3, counter saturates at 3
      step; drive_b(5, 0, 1, 0, 5, 1, 0, 0); #1;
      chk("b_ld_c1_bubble", ib.idex_bubble, 1);
      chk("b_ld_c1_busy", ib.busy, 0);
      step; drive_b(0, 0, 0, 0, 0, 0, 0, 0); #1;
      chk("b_ld_c2_busy", ib.busy, 1);
      chk("b_ld_c2_pc_write", ib.pc_write, 0);
      chk("b_ld_c2_cnt", ib.stall_cnt, 1);
      step; #1;
      chk("b_ld_c3_busy", ib.busy, 1);
      step; #1;
      chk("b_ld_c4_busy", ib.busy, 0);
      chk("b_ld_c4_pc_write", ib.pc_write, 1);
      chk("b_ld_cnt3", ib.stall_cnt, 3);
      step; drive_b(0, 5, 0, 1, 5, 1, 0, 0); #1;
      chk("b_ld2_bubble", ib.idex_bubble, 1);
      step; drive_b(0, 0, 0, 0, 0, 0, 0, 0);
      step; step; #1;
      chk("b_ld2_busy", ib.busy, 0);
      chk("b_sat_cnt", ib.stall_cnt, 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
